// File: rtl/mask_match_sequencer.sv
// mask_match_sequencer
// Streams a job made of a W/A bitmask pair, one chunk per cycle. For each chunk
// it forms the mutual mask and compacts it through the W and A masks. It then
// emits the packed masks, the per-chunk popcounts and the running offsets under
// a valid/ready handshake.
//
// Ports
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   ivalid / oready        : job handshake (oready high only in IDLE)
//   bitmaskW, bitmaskA     : NUM_CHUNKS chunks of CHUNK_WIDTH bits, chunk 0 in the LSBs
//   skipEmpty              : drop non-final chunks with an empty mutual mask
//   ovalid / iready        : output record handshake
//   packedW, packedA       : mutual bits compacted by the W / A mask, LSB first
//   numW, numA             : popcount of the chunk's W / A mask
//   offsetW, offsetA       : sum of numW / numA over all earlier chunks of the job
//   chunkIndex, last       : source chunk number, final-chunk flag
module mask_match_sequencer #(
  parameter int unsigned CHUNK_WIDTH       = 16,
  parameter int unsigned NUM_CHUNKS        = 4,
  parameter int unsigned COUNT_BITWIDTH    = 5,
  parameter int unsigned ACCUM_BITWIDTH    = 8,
  parameter int unsigned CHUNK_INDEX_WIDTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              ivalid,
  output logic                              oready,
  input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] bitmaskW,
  input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] bitmaskA,
  input  logic                              skipEmpty,
  output logic                              ovalid,
  input  logic                              iready,
  output logic [CHUNK_WIDTH-1:0]            packedW,
  output logic [CHUNK_WIDTH-1:0]            packedA,
  output logic [COUNT_BITWIDTH-1:0]         numW,
  output logic [COUNT_BITWIDTH-1:0]         numA,
  output logic [ACCUM_BITWIDTH-1:0]         offsetW,
  output logic [ACCUM_BITWIDTH-1:0]         offsetA,
  output logic [CHUNK_INDEX_WIDTH-1:0]      chunkIndex,
  output logic                              last
);

  localparam int unsigned MASK_WIDTH = CHUNK_WIDTH * NUM_CHUNKS;
  localparam logic [CHUNK_INDEX_WIDTH-1:0] LAST_IDX = CHUNK_INDEX_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                       r_state;
  state_t                       w_next_state;
  logic [MASK_WIDTH-1:0]        r_mask_w;
  logic [MASK_WIDTH-1:0]        r_mask_a;
  logic                         r_skip_empty;
  logic [CHUNK_INDEX_WIDTH-1:0] r_ptr;
  logic [ACCUM_BITWIDTH-1:0]    r_acc_w;
  logic [ACCUM_BITWIDTH-1:0]    r_acc_a;

  logic [CHUNK_WIDTH-1:0]       w_chunk_w;
  logic [CHUNK_WIDTH-1:0]       w_chunk_a;
  logic [CHUNK_WIDTH-1:0]       w_mutual;
  logic [CHUNK_WIDTH-1:0]       w_packed_w;
  logic [CHUNK_WIDTH-1:0]       w_packed_a;
  logic [COUNT_BITWIDTH-1:0]    w_num_w;
  logic [COUNT_BITWIDTH-1:0]    w_num_a;
  logic                         w_is_last;
  logic                         w_skip;
  logic                         w_accept;
  logic                         w_advance;
  logic                         w_load;

  // The masks shift down one chunk per advance, so the current chunk is always in the LSBs.
  assign w_chunk_w = r_mask_w[CHUNK_WIDTH-1:0];
  assign w_chunk_a = r_mask_a[CHUNK_WIDTH-1:0];
  assign w_mutual  = w_chunk_w & w_chunk_a;
  assign w_is_last = (r_ptr == LAST_IDX);
  assign w_skip    = r_skip_empty && (w_mutual == '0) && !w_is_last;
  assign w_load    = w_advance && !w_skip;

  // Compaction: walk from the MSB down. Each selected bit is shifted in, so the
  // lowest selected bit ends up at position 0 and the unused upper bits stay zero.
  always_comb begin
    w_packed_w = '0;
    w_packed_a = '0;
    w_num_w    = '0;
    w_num_a    = '0;
    for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
      if (w_chunk_w[i]) w_packed_w = (w_packed_w << 1) | CHUNK_WIDTH'(w_mutual[i]);
      if (w_chunk_a[i]) w_packed_a = (w_packed_a << 1) | CHUNK_WIDTH'(w_mutual[i]);
      w_num_w = w_num_w + COUNT_BITWIDTH'(w_chunk_w[i]);
      w_num_a = w_num_a + COUNT_BITWIDTH'(w_chunk_a[i]);
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state, job acceptance and chunk advance
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    oready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oready = !reset;
        if (ivalid) begin
          w_accept     = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Advance when the output register is empty or is being handed off.
        if (!ovalid || iready) begin
          w_advance = 1'b1;
          if (w_is_last) w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Job context: masks, chunk pointer and running offsets
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask_w     <= '0;
      r_mask_a     <= '0;
      r_skip_empty <= 1'b0;
      r_ptr        <= '0;
      r_acc_w      <= '0;
      r_acc_a      <= '0;
    end else if (w_accept) begin
      r_mask_w     <= bitmaskW;
      r_mask_a     <= bitmaskA;
      r_skip_empty <= skipEmpty;
      r_ptr        <= '0;
      r_acc_w      <= '0;
      r_acc_a      <= '0;
    end else if (w_advance) begin
      r_mask_w <= r_mask_w >> CHUNK_WIDTH;
      r_mask_a <= r_mask_a >> CHUNK_WIDTH;
      r_ptr    <= r_ptr + CHUNK_INDEX_WIDTH'(1);
      r_acc_w  <= r_acc_w + ACCUM_BITWIDTH'(w_num_w);
      r_acc_a  <= r_acc_a + ACCUM_BITWIDTH'(w_num_a);
    end
  end

  // Output record register; the fields only change when a new record loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovalid     <= 1'b0;
      packedW    <= '0;
      packedA    <= '0;
      numW       <= '0;
      numA       <= '0;
      offsetW    <= '0;
      offsetA    <= '0;
      chunkIndex <= '0;
      last       <= 1'b0;
    end else if (w_load) begin
      ovalid     <= 1'b1;
      packedW    <= w_packed_w;
      packedA    <= w_packed_a;
      numW       <= w_num_w;
      numA       <= w_num_a;
      offsetW    <= r_acc_w;
      offsetA    <= r_acc_a;
      chunkIndex <= r_ptr;
      last       <= w_is_last;
    end else if (iready) begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mask_match_sequencer.sv
module tb_mask_match_sequencer;

  localparam int unsigned CW  = 16;
  localparam int unsigned NC  = 4;
  localparam int unsigned CBW = 5;
  localparam int unsigned ABW = 8;
  localparam int unsigned CIW = 2;
  localparam int unsigned MW  = CW * NC;

  localparam logic [MW-1:0] W0 = 64'hFFFF_0000_00F0_000F;
  localparam logic [MW-1:0] A0 = 64'h8000_FFFF_0030_0005;

  typedef struct packed {
    logic [CW-1:0]  pw;
    logic [CW-1:0]  pa;
    logic [CBW-1:0] nw;
    logic [CBW-1:0] na;
    logic [ABW-1:0] ow;
    logic [ABW-1:0] oa;
    logic [CIW-1:0] idx;
    logic           last;
  } rec_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           ivalid = 1'b0;
  logic           skipEmpty = 1'b0;
  logic [MW-1:0]  bitmaskW = '0;
  logic [MW-1:0]  bitmaskA = '0;
  logic           iready;
  logic           iready_dir = 1'b1;
  logic           rand_ready = 1'b0;
  logic           r_rand_ready = 1'b1;
  logic           oready;
  logic           ovalid;
  logic [CW-1:0]  packedW;
  logic [CW-1:0]  packedA;
  logic [CBW-1:0] numW;
  logic [CBW-1:0] numA;
  logic [ABW-1:0] offsetW;
  logic [ABW-1:0] offsetA;
  logic [CIW-1:0] chunkIndex;
  logic           last;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rec_t exp_q[$];
  int   xq[$];
  int   acc_q[$];

  mask_match_sequencer #(
    .CHUNK_WIDTH(CW), .NUM_CHUNKS(NC), .COUNT_BITWIDTH(CBW),
    .ACCUM_BITWIDTH(ABW), .CHUNK_INDEX_WIDTH(CIW)
  ) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
    .bitmaskW(bitmaskW), .bitmaskA(bitmaskA), .skipEmpty(skipEmpty),
    .ovalid(ovalid), .iready(iready), .packedW(packedW), .packedA(packedA),
    .numW(numW), .numA(numA), .offsetW(offsetW), .offsetA(offsetA),
    .chunkIndex(chunkIndex), .last(last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign iready = rand_ready ? r_rand_ready : iready_dir;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      r_rand_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: for each chunk, compact the mutual bits by walking the set-bit list of each mask.
  function automatic void model_job(input logic [MW-1:0] wm, input logic [MW-1:0] am, input logic sk);
    int ow, oa, kw, ka;
    logic [CW-1:0] w, a, m, pw, pa;
    rec_t r;
    ow = 0;
    oa = 0;
    for (int c = 0; c < int'(NC); c++) begin
      w = CW'(wm >> (c * CW));
      a = CW'(am >> (c * CW));
      m = w & a;
      pw = '0; pa = '0; kw = 0; ka = 0;
      for (int i = 0; i < int'(CW); i++) begin
        if (w[i]) begin pw[kw] = m[i]; kw++; end
        if (a[i]) begin pa[ka] = m[i]; ka++; end
      end
      if (!(sk && m == '0 && c != int'(NC) - 1)) begin
        r.pw = pw; r.pa = pa;
        r.nw = CBW'(kw); r.na = CBW'(ka);
        r.ow = ABW'(ow); r.oa = ABW'(oa);
        r.idx = CIW'(c);
        r.last = (c == int'(NC) - 1);
        exp_q.push_back(r);
      end
      ow += kw;
      oa += ka;
    end
  endfunction

  // Acceptance observer: the job is taken at the coming rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && ivalid && oready) begin
        model_job(bitmaskW, bitmaskA, skipEmpty);
        acc_q.push_back(cyc);
      end
    end
  end

  // Output monitor: scoreboard compare on handoff, stability check while stalled.
  initial begin
    rec_t act, prev, e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      act.pw = packedW; act.pa = packedA; act.nw = numW; act.na = numA;
      act.ow = offsetW; act.oa = offsetA; act.idx = chunkIndex; act.last = last;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 64'(ovalid), 64'd1);
          check("stall_hold_fields", 64'(act), 64'(prev));
        end
        if (ovalid && iready) begin
          xq.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_record: actual=%0h required=none", act);
          end else begin
            e = exp_q.pop_front();
            check("record", 64'(act), 64'(e));
          end
        end
        prev_stall = ovalid && !iready;
        prev = act;
      end
    end
  end

  // Present a job starting just after a rising edge; returns 1ns after the accepting edge.
  task automatic send_job(input logic [MW-1:0] wm, input logic [MW-1:0] am, input logic sk);
    int n;
    bitmaskW = wm;
    bitmaskA = am;
    skipEmpty = sk;
    ivalid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!oready && n < 200);
    if (!oready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual=oready_low required=accept_within_200");
    end
    @(posedge clock);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ovalid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual=pending=%0d required=0", exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_mask();
    logic [MW-1:0] m;
    int sel;
    m = '0;
    for (int c = 0; c < int'(NC); c++) begin
      sel = $urandom_range(0, 3);
      if (sel == 1)      m = m | (MW'({CW{1'b1}}) << (c * CW));
      else if (sel >= 2) m = m | (MW'(CW'($urandom())) << (c * CW));
    end
    return m;
  endfunction

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_ovalid", 64'(ovalid), 64'd0);
    check("reset_oready", 64'(oready), 64'd0);
    check("reset_fields", 64'({packedW, packedA, numW, numA, offsetW, offsetA, chunkIndex, last}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("oready_after_reset", 64'(oready), 64'd1);

    // plain job: latency and full throughput
    xq.delete(); acc_q.delete();
    send_job(W0, A0, 1'b0);
    check("latency_not_yet", 64'(ovalid), 64'd0);
    check("busy_oready", 64'(oready), 64'd0);
    @(posedge clock);
    #1;
    check("latency_ovalid", 64'(ovalid), 64'd1);
    check("latency_chunk0", 64'(chunkIndex), 64'd0);
    drain();
    check("plain_count", 64'(xq.size()), 64'd4);
    if (xq.size() == 4 && acc_q.size() == 1) begin
      check("plain_first_latency", 64'(xq[0] - acc_q[0]), 64'd2);
      check("plain_throughput", 64'(xq[3] - xq[0]), 64'd3);
    end

    // skipEmpty: chunk 2 dropped, one bubble before chunk 3
    xq.delete(); acc_q.delete();
    send_job(W0, A0, 1'b1);
    drain();
    check("skip_count", 64'(xq.size()), 64'd3);
    if (xq.size() == 3) begin
      check("skip_gap01", 64'(xq[1] - xq[0]), 64'd1);
      check("skip_bubble", 64'(xq[2] - xq[1]), 64'd2);
    end

    // all chunks empty: only the forced final record
    xq.delete(); acc_q.delete();
    send_job({MW{1'b1}}, '0, 1'b1);
    drain();
    check("allskip_count", 64'(xq.size()), 64'd1);
    if (xq.size() == 1 && acc_q.size() == 1)
      check("allskip_latency", 64'(xq[0] - acc_q[0]), 64'd5);

    // backpressure on the chunk 1 record
    xq.delete(); acc_q.delete();
    send_job(W0, A0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    iready_dir = 1'b0;
    check("bp_chunk1", 64'(chunkIndex), 64'd1);
    repeat (3) begin
      @(posedge clock); #1;
      check("bp_oready", 64'(oready), 64'd0);
      check("bp_ovalid_idx", 64'({ovalid, chunkIndex}), 64'({1'b1, 2'd1}));
    end
    iready_dir = 1'b1;
    drain();
    check("bp_count", 64'(xq.size()), 64'd4);

    // back-to-back jobs
    xq.delete(); acc_q.delete();
    send_job(W0, A0, 1'b0);
    send_job(rand_mask(), rand_mask(), 1'b0);
    drain();
    check("b2b_count", 64'(xq.size()), 64'd8);
    if (acc_q.size() == 2)
      check("b2b_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'd5);

    // reset in the middle of a stalled job
    iready_dir = 1'b0;
    send_job(W0, A0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midreset_pre_valid", 64'(ovalid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_ovalid", 64'(ovalid), 64'd0);
    check("midreset_oready", 64'(oready), 64'd0);
    check("midreset_fields", 64'({packedW, packedA, numW, numA, offsetW, offsetA, chunkIndex, last}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    iready_dir = 1'b1;
    @(posedge clock); #1;
    check("midreset_oready_release", 64'(oready), 64'd1);
    repeat (6) @(posedge clock);
    #1;
    check("midreset_no_stale", 64'(ovalid), 64'd0);

    // randomized jobs with random downstream stalls
    rand_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      send_job(rand_mask(), rand_mask(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
